word_access_ctrl: RTL and testbench

WORD_ACCESS_CTRL -- requirements
Module: word_access_ctrl

---
 rtl/word_access_ctrl_pkg.sv | 29 ++
 rtl/word_access_ctrl_if.sv | 23 ++
 rtl/word_access_ctrl.sv | 141 ++++++++++++++
 tb/tb_word_access_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/word_access_ctrl_pkg.sv
// Shared definitions for the byte-serial word access controller:
// state encoding, word geometry and the big-endian byte-lane selector.
package word_access_ctrl_pkg;

    localparam int WORD_BYTES = 4;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Byte count at which a transfer finishes
    localparam logic [1:0] LAST_WORD_CNT = 2'(WORD_BYTES - 1);
    localparam logic [1:0] LAST_BYTE_CNT = 2'd0;

    // Big-endian lane pick: count 0 is the most significant byte
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] lane_s;
        case (idx)
            2'd0:    lane_s = word[31:24];
            2'd1:    lane_s = word[23:16];
            2'd2:    lane_s = word[15:8];
            2'd3:    lane_s = word[7:0];
            default: lane_s = 8'h00;
        endcase
        return lane_s;
    endfunction

endpackage

// File: rtl/word_access_ctrl_if.sv
// Client request/response channel of the word access controller.
interface word_access_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_word;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;

    modport master (
        output req_valid, req_write, req_word, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_word, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/word_access_ctrl.sv
// Word access controller: turns single-byte or 4-byte load/store requests
// into a byte-per-cycle sequence on a byte-wide memory (big-endian order).
// All outputs are flops loaded from next-state values, so they line up with
// the state they describe without any combinational path to the pins.
import word_access_ctrl_pkg::*;

module word_access_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              ph1,
    input  logic              reset,
    word_access_ctrl_if.slave bus,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [7:0]        Write_data,
    input  logic [7:0]        MemData
);

    logic [1:0]        state_r, state_nxt_s;
    logic [1:0]        count_r, count_nxt_s;
    logic [ADDR_W-1:0] base_r, base_nxt_s;
    logic [31:0]       wdata_r, wdata_nxt_s;
    logic              write_r, write_nxt_s;
    logic              word_r, word_nxt_s;
    logic [31:0]       buf_r, buf_nxt_s;
    logic [31:0]       shifted_s;

    logic              req_ready_r, resp_valid_r;
    logic [31:0]       resp_rdata_r, rdata_nxt_s;
    logic              mem_read_r, mem_write_r;
    logic [ADDR_W-1:0] address_r, address_nxt_s;
    logic [7:0]        write_data_r, write_data_nxt_s;
    logic              xfer_nxt_s;

    assign shifted_s = {buf_r[23:0], MemData};

    // Next-state logic: request capture, byte sequencing and load assembly
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        base_nxt_s  = base_r;
        wdata_nxt_s = wdata_r;
        write_nxt_s = write_r;
        word_nxt_s  = word_r;
        buf_nxt_s   = buf_r;
        rdata_nxt_s = resp_rdata_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_nxt_s = ST_XFER;
                    count_nxt_s = 2'd0;
                    base_nxt_s  = bus.req_addr;
                    wdata_nxt_s = bus.req_wdata;
                    write_nxt_s = bus.req_write;
                    word_nxt_s  = bus.req_word;
                    buf_nxt_s   = 32'h0000_0000;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (!write_r) begin
                    buf_nxt_s = shifted_s;
                end else begin
                    buf_nxt_s = buf_r;
                end
                if (count_r == (word_r ? LAST_WORD_CNT : LAST_BYTE_CNT)) begin
                    state_nxt_s = ST_RESP;
                    rdata_nxt_s = write_r ? 32'h0000_0000 : shifted_s;
                end else begin
                    count_nxt_s = count_r + 2'd1;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                count_nxt_s = 2'd0;
            end
        endcase
    end

    // Memory-side output values for the cycle being entered
    always_comb begin
        xfer_nxt_s = (state_nxt_s == ST_XFER);
        if (xfer_nxt_s) begin
            address_nxt_s    = base_nxt_s + ADDR_W'(count_nxt_s);
            write_data_nxt_s = word_nxt_s ? byte_lane(wdata_nxt_s, count_nxt_s)
                                          : wdata_nxt_s[7:0];
        end else begin
            address_nxt_s    = {ADDR_W{1'b0}};
            write_data_nxt_s = 8'h00;
        end
    end

    // State, latched request and registered outputs
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            count_r      <= 2'd0;
            base_r       <= {ADDR_W{1'b0}};
            wdata_r      <= 32'h0000_0000;
            write_r      <= 1'b0;
            word_r       <= 1'b0;
            buf_r        <= 32'h0000_0000;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            address_r    <= {ADDR_W{1'b0}};
            write_data_r <= 8'h00;
        end else begin
            state_r      <= state_nxt_s;
            count_r      <= count_nxt_s;
            base_r       <= base_nxt_s;
            wdata_r      <= wdata_nxt_s;
            write_r      <= write_nxt_s;
            word_r       <= word_nxt_s;
            buf_r        <= buf_nxt_s;
            req_ready_r  <= (state_nxt_s == ST_IDLE);
            resp_valid_r <= (state_nxt_s == ST_RESP);
            resp_rdata_r <= rdata_nxt_s;
            mem_read_r   <= xfer_nxt_s && !write_nxt_s;
            mem_write_r  <= xfer_nxt_s && write_nxt_s;
            address_r    <= address_nxt_s;
            write_data_r <= write_data_nxt_s;
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign MemRead        = mem_read_r;
    assign MemWrite       = mem_write_r;
    assign Address        = address_r;
    assign Write_data     = write_data_r;

endmodule

// File: tb/tb_word_access_ctrl.sv
// Directed self-checking bench for word_access_ctrl with a 256-byte memory.
module tb_word_access_ctrl;

    logic        ph1 = 1'b0;
    logic        reset;
    logic        mem_rst;
    logic        MemRead, MemWrite;
    logic [7:0]  Address, Write_data, MemData;
    logic [7:0]  mem [0:255];

    int          checks = 0;
    int          failures = 0;
    int          lat;
    int          nb;
    logic [31:0] apack, dpack;
    logic        saw_resp;

    word_access_ctrl_if #(.ADDR_W(8)) bus ();

    word_access_ctrl #(.ADDR_W(8)) dut (
        .ph1        (ph1),
        .reset      (reset),
        .bus        (bus.slave),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .Write_data (Write_data),
        .MemData    (MemData)
    );

    always #5 ph1 = ~ph1;

    // Byte memory: boot image on mem_rst, synchronous write, async read
    always @(posedge ph1) begin
        if (mem_rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[0]   <= 8'h20;
            mem[1]   <= 8'h03;
            mem[2]   <= 8'h00;
            mem[3]   <= 8'h08;
            mem[10]  <= 8'hFF;
            mem[100] <= 8'hA0;
            mem[101] <= 8'hA1;
            mem[102] <= 8'hA2;
            mem[103] <= 8'hA3;
        end else if (MemWrite) begin
            mem[Address] <= Write_data;
        end
    end
    assign MemData = MemRead ? mem[Address] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request, let it be accepted, then scramble the inputs
    task automatic accept(input logic wr, input logic wd, input logic [7:0] a, input logic [31:0] d);
        @(negedge ph1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_word  = wd;
        bus.req_addr  = a;
        bus.req_wdata = d;
        chk("accept_ready", 32'(bus.req_ready), 32'd1);
        @(posedge ph1);
        #1;
        bus.req_valid = 1'b0;
        bus.req_write = ~wr;
        bus.req_word  = ~wd;
        bus.req_addr  = 8'h5C;
        bus.req_wdata = 32'hCAFE_F00D;
        @(negedge ph1);
    endtask

    // From the first XFER negedge, collect bus bytes until resp_valid (bounded)
    task automatic wait_resp(output int l, output logic [31:0] ap, output logic [31:0] dp, output int n);
        l  = -1;
        ap = 32'h0;
        dp = 32'h0;
        n  = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.resp_valid) begin
                l = k + 1;
                break;
            end
            if (MemRead || MemWrite) begin
                ap = {ap[23:0], Address};
                dp = {dp[23:0], Write_data};
                n++;
            end
            @(negedge ph1);
        end
    endtask

    initial begin
        reset         = 1'b1;
        mem_rst       = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_word  = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 32'h0;

        // Reset values
        @(negedge ph1);
        chk("rst_ready",      32'(bus.req_ready),  32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata",      bus.resp_rdata,      32'd0);
        chk("rst_memread",    32'(MemRead),        32'd0);
        chk("rst_memwrite",   32'(MemWrite),       32'd0);
        chk("rst_address",    32'(Address),        32'd0);
        chk("rst_wdata",      32'(Write_data),     32'd0);
        @(negedge ph1);
        reset   = 1'b0;
        mem_rst = 1'b0;

        // Word load from boot image at 0
        accept(1'b0, 1'b1, 8'd0, 32'h0);
        chk("wl_memread",  32'(MemRead),       32'd1);
        chk("wl_memwrite", 32'(MemWrite),      32'd0);
        chk("wl_address0", 32'(Address),       32'd0);
        chk("wl_ready",    32'(bus.req_ready), 32'd0);
        wait_resp(lat, apack, dpack, nb);
        chk("wl_latency",  32'(lat),       32'd5);
        chk("wl_addrseq",  apack,          32'h0001_0203);
        chk("wl_rdata",    bus.resp_rdata, 32'h2003_0008);
        @(negedge ph1);
        chk("wl_pulse",    32'(bus.resp_valid), 32'd0);
        chk("wl_idle",     32'(bus.req_ready),  32'd1);
        chk("wl_hold",     bus.resp_rdata,      32'h2003_0008);
        chk("wl_idle_mr",  32'(MemRead),        32'd0);

        // Byte load at 10
        accept(1'b0, 1'b0, 8'd10, 32'h0);
        wait_resp(lat, apack, dpack, nb);
        chk("bl_latency", 32'(lat),       32'd2);
        chk("bl_rdata",   bus.resp_rdata, 32'h0000_00FF);

        // Byte store at 255 uses only wdata[7:0]
        accept(1'b1, 1'b0, 8'd255, 32'hAABB_CC5A);
        chk("bs_memwrite", 32'(MemWrite),   32'd1);
        chk("bs_memread",  32'(MemRead),    32'd0);
        chk("bs_address",  32'(Address),    32'd255);
        chk("bs_wdata",    32'(Write_data), 32'h5A);
        wait_resp(lat, apack, dpack, nb);
        chk("bs_latency",  32'(lat),        32'd2);
        chk("bs_rdata",    bus.resp_rdata,  32'd0);
        chk("bs_mem255",   32'(mem[255]),   32'h5A);
        accept(1'b0, 1'b0, 8'd255, 32'h0);
        wait_resp(lat, apack, dpack, nb);
        chk("bs_readback", bus.resp_rdata,  32'h0000_005A);

        // Word store / load across the address wrap
        accept(1'b1, 1'b1, 8'd254, 32'hDEAD_BEEF);
        wait_resp(lat, apack, dpack, nb);
        chk("ws_latency", 32'(lat), 32'd5);
        chk("ws_nbytes",  32'(nb),  32'd4);
        chk("ws_addrseq", apack,    32'hFEFF_0001);
        chk("ws_dataseq", dpack,    32'hDEAD_BEEF);
        accept(1'b0, 1'b1, 8'd254, 32'h0);
        wait_resp(lat, apack, dpack, nb);
        chk("wr_addrseq", apack,          32'hFEFF_0001);
        chk("wr_rdata",   bus.resp_rdata, 32'hDEAD_BEEF);

        // Reset between the 2nd and 3rd XFER edges of a word store
        accept(1'b1, 1'b1, 8'd100, 32'h1122_3344);
        @(posedge ph1);
        @(posedge ph1);
        @(negedge ph1);
        reset = 1'b1;
        #1;
        chk("ab_memwrite", 32'(MemWrite),       32'd0);
        chk("ab_address",  32'(Address),        32'd0);
        chk("ab_ready",    32'(bus.req_ready),  32'd1);
        saw_resp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge ph1);
            saw_resp = saw_resp | bus.resp_valid;
        end
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge ph1);
            saw_resp = saw_resp | bus.resp_valid;
        end
        chk("ab_no_resp", 32'(saw_resp), 32'd0);
        chk("ab_mem100",  32'(mem[100]), 32'h11);
        chk("ab_mem101",  32'(mem[101]), 32'h22);
        chk("ab_mem102",  32'(mem[102]), 32'hA2);
        chk("ab_mem103",  32'(mem[103]), 32'hA3);

        // req_valid held high: next acceptance only after the response cycle
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_word  = 1'b0;
        bus.req_addr  = 8'd10;
        chk("hv_ready0", 32'(bus.req_ready), 32'd1);
        @(negedge ph1);
        chk("hv_xfer_ready", 32'(bus.req_ready), 32'd0);
        chk("hv_xfer_mr",    32'(MemRead),       32'd1);
        @(negedge ph1);
        chk("hv_resp",       32'(bus.resp_valid), 32'd1);
        chk("hv_resp_ready", 32'(bus.req_ready),  32'd0);
        @(negedge ph1);
        chk("hv_idle_ready", 32'(bus.req_ready),  32'd1);
        chk("hv_idle_resp",  32'(bus.resp_valid), 32'd0);
        @(negedge ph1);
        chk("hv_second_acc", 32'(MemRead),        32'd1);
        chk("hv_second_rdy", 32'(bus.req_ready),  32'd0);
        bus.req_valid = 1'b0;
        @(negedge ph1);
        chk("hv_second_resp", 32'(bus.resp_valid), 32'd1);
        chk("hv_second_data", bus.resp_rdata,      32'h0000_00FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
